// File: rtl/lcd_bus_receiver.sv
// Panel-side receiver for an 8080-style LCD write bus: synchronizes the bus,
// captures bytes on strobe rising edges, queues tokens and tracks panel state.
module lcd_bus_receiver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_command,
    input  logic        send_data,
    input  logic        disp_cs,
    input  logic        disp_reset,
    output logic        tok_valid,
    input  logic        tok_ready,
    output logic [7:0]  tok_data,
    output logic        tok_is_cmd,
    output logic [3:0]  tok_param_idx,
    output logic [7:0]  last_cmd,
    output logic        sleep_out,
    output logic        display_on,
    output logic [7:0]  pixel_format,
    output logic        overflow,
    output logic [15:0] byte_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = 13;

    logic [SYNC_STAGES-1:0][11:0] sync_q;
    logic [11:0]    busS;
    logic [7:0]     dataS;
    logic           dcS, sendS, csS, rstnS;

    logic           sendPrev_q;
    logic [AW:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [TW-1:0]  mem_q [FIFO_DEPTH];
    logic [TW-1:0]  headLast_q, headLast_d;
    logic [TW-1:0]  headTok, tokIn;
    logic [7:0]     lastCmd_q, lastCmd_d;
    logic [7:0]     pixFmt_q, pixFmt_d;
    logic           sleep_q, sleep_d;
    logic           dispOn_q, dispOn_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    byteCount_q, byteCount_d;
    logic [3:0]     param_q, param_d;

    logic           strobeRise, capture, pop, push, empty, full;

    // All bus signals share one synchronizer chain so byte, select and strobe stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {disp_reset, disp_cs, send_data, data_command, data_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign busS  = sync_q[SYNC_STAGES-1];
    assign dataS = busS[7:0];
    assign dcS   = busS[8];
    assign sendS = busS[9];
    assign csS   = busS[10];
    assign rstnS = busS[11];

    assign empty   = (wrPtr_q == rdPtr_q);
    assign full    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign headTok = empty ? headLast_q : mem_q[rdPtr_q[AW-1:0]];
    assign tokIn   = {~dcS, (dcS ? param_q : 4'd0), dataS};

    always_comb begin
        strobeRise  = sendS & ~sendPrev_q;
        capture     = strobeRise & ~csS & rstnS;
        pop         = ~empty & tok_ready;
        push        = capture & (~full | pop);

        wrPtr_d     = wrPtr_q + {{AW{1'b0}}, push};
        rdPtr_d     = rdPtr_q + {{AW{1'b0}}, pop};
        headLast_d  = pop ? headTok : headLast_q;
        lastCmd_d   = lastCmd_q;
        pixFmt_d    = pixFmt_q;
        sleep_d     = sleep_q;
        dispOn_d    = dispOn_q;
        overflow_d  = overflow_q | (capture & full & ~pop);
        byteCount_d = byteCount_q;
        param_d     = param_q;

        if (capture) begin
            if (byteCount_q != 16'hFFFF) begin
                byteCount_d = byteCount_q + 16'd1;
            end
            if (!dcS) begin
                lastCmd_d = dataS;
                param_d   = 4'd0;
                case (dataS)
                    8'h11: sleep_d  = 1'b1;
                    8'h10: sleep_d  = 1'b0;
                    8'h29: dispOn_d = 1'b1;
                    8'h28: dispOn_d = 1'b0;
                    8'h01: begin
                        sleep_d  = 1'b0;
                        dispOn_d = 1'b0;
                        pixFmt_d = 8'h00;
                    end
                    default: ;
                endcase
            end else begin
                if (param_q == 4'd0 && lastCmd_q == 8'h3A) begin
                    pixFmt_d = dataS;
                end
                if (param_q != 4'd15) begin
                    param_d = param_q + 4'd1;
                end
            end
        end

        // Panel reset flushes the queue and state but keeps the sticky overflow flag.
        if (!rstnS) begin
            rdPtr_d     = wrPtr_q;
            wrPtr_d     = wrPtr_q;
            lastCmd_d   = 8'h00;
            pixFmt_d    = 8'h00;
            sleep_d     = 1'b0;
            dispOn_d    = 1'b0;
            byteCount_d = 16'h0000;
            param_d     = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sendPrev_q  <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            headLast_q  <= '0;
            lastCmd_q   <= 8'h00;
            pixFmt_q    <= 8'h00;
            sleep_q     <= 1'b0;
            dispOn_q    <= 1'b0;
            overflow_q  <= 1'b0;
            byteCount_q <= 16'h0000;
            param_q     <= 4'd0;
        end else begin
            sendPrev_q  <= sendS;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            headLast_q  <= headLast_d;
            lastCmd_q   <= lastCmd_d;
            pixFmt_q    <= pixFmt_d;
            sleep_q     <= sleep_d;
            dispOn_q    <= dispOn_d;
            overflow_q  <= overflow_d;
            byteCount_q <= byteCount_d;
            param_q     <= param_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q[AW-1:0]] <= tokIn;
        end
    end

    assign tok_valid     = ~empty;
    assign tok_is_cmd    = headTok[12];
    assign tok_param_idx = headTok[11:8];
    assign tok_data      = headTok[7:0];
    assign last_cmd      = lastCmd_q;
    assign sleep_out     = sleep_q;
    assign display_on    = dispOn_q;
    assign pixel_format  = pixFmt_q;
    assign overflow      = overflow_q;
    assign byte_count    = byteCount_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed self-checking bench for lcd_bus_receiver: token stream, decode,
// FIFO overflow/drain, chip select, parameter indexing and both resets.
module tb_lcd_bus_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        data_command = 1'b0;
    logic        send_data = 1'b0;
    logic        disp_cs = 1'b0;
    logic        disp_reset = 1'b1;
    logic        tok_ready = 1'b0;
    logic        tok_valid, tok_is_cmd, sleep_out, display_on, overflow;
    logic [7:0]  tok_data, last_cmd, pixel_format;
    logic [3:0]  tok_param_idx;
    logic [15:0] byte_count;

    int checks = 0;
    int passes = 0;
    logic [12:0] tokQ[$];

    lcd_bus_receiver #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_command(data_command),
        .send_data(send_data), .disp_cs(disp_cs), .disp_reset(disp_reset),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
        .tok_is_cmd(tok_is_cmd), .tok_param_idx(tok_param_idx), .last_cmd(last_cmd),
        .sleep_out(sleep_out), .display_on(display_on), .pixel_format(pixel_format),
        .overflow(overflow), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Record every token the consumer accepts as {is_cmd, idx, data}.
    always @(negedge clk) begin
        if (tok_valid && tok_ready) tokQ.push_back({tok_is_cmd, tok_param_idx, tok_data});
    end

    task automatic doReset();
        rst = 1'b1; send_data = 1'b0; disp_cs = 1'b0; disp_reset = 1'b1; tok_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 tokQ.delete();
    endtask

    task automatic writeByte(input logic isData, input logic [7:0] b);
        @(posedge clk); #1;
        data_in = b; data_command = isData; send_data = 1'b0;
        repeat (3) @(posedge clk);
        #1 send_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 send_data = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({tok_valid, tok_data, tok_is_cmd, tok_param_idx, last_cmd, sleep_out, display_on,
             pixel_format, overflow, byte_count} !== 55'd0)
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h cnt=%h ovf=%b want all zero",
                     tok_valid, tok_data, byte_count, overflow);
        else passes++;
        doReset();
    endtask

    task automatic test_basic_stream();
        logic [12:0] exp [3];
        exp[0] = {1'b1, 4'd0, 8'hC0};
        exp[1] = {1'b0, 4'd0, 8'h11};
        exp[2] = {1'b0, 4'd1, 8'h09};
        doReset();
        tok_ready = 1'b1;
        writeByte(1'b0, 8'hC0);
        writeByte(1'b1, 8'h11);
        writeByte(1'b1, 8'h09);
        @(negedge clk);
        checks++;
        if (tokQ.size() !== 3) $display("[TB] FAIL basic_count: got %0d want 3", tokQ.size());
        else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= tokQ.size() || tokQ[i] !== exp[i])
                $display("[TB] FAIL basic_tok%0d: got %h want %h", i, (i < tokQ.size()) ? tokQ[i] : 13'h0, exp[i]);
            else passes++;
        end
        checks++;
        if (last_cmd !== 8'hC0) $display("[TB] FAIL basic_last_cmd: got %h want C0", last_cmd);
        else passes++;
        checks++;
        if (byte_count !== 16'd3) $display("[TB] FAIL basic_byte_count: got %0d want 3", byte_count);
        else passes++;
        checks++;
        if (sleep_out !== 1'b0) $display("[TB] FAIL basic_data11_not_sleep: got %b want 0", sleep_out);
        else passes++;
    endtask

    task automatic test_decode();
        doReset();
        tok_ready = 1'b1;
        writeByte(1'b0, 8'h3A);
        writeByte(1'b1, 8'h66);
        writeByte(1'b1, 8'h77);
        writeByte(1'b0, 8'h11);
        writeByte(1'b0, 8'h29);
        @(negedge clk);
        checks++;
        if (pixel_format !== 8'h66) $display("[TB] FAIL decode_pixfmt: got %h want 66", pixel_format);
        else passes++;
        checks++;
        if (sleep_out !== 1'b1) $display("[TB] FAIL decode_sleep_out: got %b want 1", sleep_out);
        else passes++;
        checks++;
        if (display_on !== 1'b1) $display("[TB] FAIL decode_disp_on: got %b want 1", display_on);
        else passes++;
        writeByte(1'b0, 8'h28);
        @(negedge clk);
        checks++;
        if ({display_on, sleep_out} !== 2'b01)
            $display("[TB] FAIL decode_disp_off: got disp=%b sleep=%b want disp=0 sleep=1", display_on, sleep_out);
        else passes++;
        writeByte(1'b0, 8'h01);
        @(negedge clk);
        checks++;
        if ({sleep_out, display_on, pixel_format, last_cmd} !== {2'b00, 8'h00, 8'h01})
            $display("[TB] FAIL decode_soft_reset: got sleep=%b disp=%b pix=%h last=%h want 0 0 00 01",
                     sleep_out, display_on, pixel_format, last_cmd);
        else passes++;
    endtask

    task automatic test_latency();
        int n;
        doReset();
        @(posedge clk); #1;
        data_in = 8'h5A; data_command = 1'b0;
        repeat (3) @(posedge clk);
        #1 send_data = 1'b1;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (tok_valid) break;
        end
        checks++;
        if (n < 3 || n > 5) $display("[TB] FAIL latency_edges: got %0d want 3..5", n);
        else passes++;
        #1 send_data = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_overflow_drain();
        logic [12:0] exp [4];
        exp[0] = {1'b1, 4'd0, 8'hA0};
        exp[1] = {1'b0, 4'd0, 8'h01};
        exp[2] = {1'b0, 4'd1, 8'h02};
        exp[3] = {1'b0, 4'd2, 8'h03};
        doReset();
        writeByte(1'b0, 8'hA0);
        for (int i = 1; i <= 5; i++) writeByte(1'b1, 8'(i));
        @(negedge clk);
        checks++;
        if ({tok_valid, overflow, byte_count} !== {2'b11, 16'd6})
            $display("[TB] FAIL ovf_state: got valid=%b ovf=%b cnt=%0d want 1 1 6", tok_valid, overflow, byte_count);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (!tok_valid || {tok_is_cmd, tok_param_idx, tok_data} !== exp[i])
                $display("[TB] FAIL drain_tok%0d: got valid=%b tok=%h want 1 %h",
                         i, tok_valid, {tok_is_cmd, tok_param_idx, tok_data}, exp[i]);
            else passes++;
            #1 tok_ready = 1'b1;
            @(posedge clk);
            #1 tok_ready = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({tok_valid, tok_is_cmd, tok_param_idx, tok_data} !== {2'b00, 4'd2, 8'h03})
            $display("[TB] FAIL drain_empty_hold: got valid=%b tok=%h want 0 with held 203",
                     tok_valid, {tok_is_cmd, tok_param_idx, tok_data});
        else passes++;
    endtask

    task automatic test_chip_select();
        doReset();
        tok_ready = 1'b1;
        disp_cs = 1'b1;
        writeByte(1'b0, 8'h2C);
        @(negedge clk);
        checks++;
        if ({tokQ.size() == 0, byte_count} !== {1'b1, 16'd0})
            $display("[TB] FAIL cs_high_ignored: got tokens=%0d cnt=%0d want 0 0", tokQ.size(), byte_count);
        else passes++;
        disp_cs = 1'b0;
        writeByte(1'b1, 8'h55);
        @(negedge clk);
        checks++;
        if (tokQ.size() != 1 || tokQ[0] !== {1'b0, 4'd0, 8'h55} || last_cmd !== 8'h00)
            $display("[TB] FAIL data_before_cmd: got n=%0d tok=%h last=%h want 1 055 00",
                     tokQ.size(), (tokQ.size() > 0) ? tokQ[0] : 13'h0, last_cmd);
        else passes++;
    endtask

    task automatic test_param_idx();
        logic [12:0] expTok;
        doReset();
        tok_ready = 1'b1;
        writeByte(1'b0, 8'hE0);
        for (int k = 0; k < 17; k++) begin
            if (k == 5) begin
                disp_cs = 1'b1;
                repeat (5) @(posedge clk);
                #1 disp_cs = 1'b0;
            end
            writeByte(1'b1, 8'h10 + 8'(k));
        end
        @(negedge clk);
        checks++;
        if (tokQ.size() !== 18) $display("[TB] FAIL param_count: got %0d want 18", tokQ.size());
        else passes++;
        for (int k = 0; k < 18; k++) begin
            if (k == 0) expTok = {1'b1, 4'd0, 8'hE0};
            else expTok = {1'b0, (k - 1 > 15) ? 4'd15 : 4'(k - 1), 8'h10 + 8'(k - 1)};
            checks++;
            if (k >= tokQ.size() || tokQ[k] !== expTok)
                $display("[TB] FAIL param_tok%0d: got %h want %h", k, (k < tokQ.size()) ? tokQ[k] : 13'h0, expTok);
            else passes++;
        end
    endtask

    task automatic test_panel_reset();
        doReset();
        writeByte(1'b0, 8'h3A);
        writeByte(1'b1, 8'h66);
        writeByte(1'b0, 8'h11);
        writeByte(1'b0, 8'h29);
        writeByte(1'b0, 8'h28);
        @(negedge clk);
        #1 disp_reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tok_valid, sleep_out, display_on, pixel_format, last_cmd, byte_count, overflow}
            !== {3'b000, 8'h00, 8'h00, 16'd0, 1'b1})
            $display("[TB] FAIL panel_reset_state: got valid=%b sleep=%b disp=%b pix=%h last=%h cnt=%0d ovf=%b want 0 0 0 00 00 0 1",
                     tok_valid, sleep_out, display_on, pixel_format, last_cmd, byte_count, overflow);
        else passes++;
        writeByte(1'b0, 8'h11);
        @(negedge clk);
        checks++;
        if ({tok_valid, byte_count, sleep_out} !== {1'b0, 16'd0, 1'b0})
            $display("[TB] FAIL panel_reset_ignores_strobe: got valid=%b cnt=%0d sleep=%b want 0 0 0",
                     tok_valid, byte_count, sleep_out);
        else passes++;
        #1 disp_reset = 1'b1;
        repeat (4) @(posedge clk);
        writeByte(1'b0, 8'h11);
        writeByte(1'b1, 8'h42);
        @(negedge clk);
        checks++;
        if ({tok_valid, sleep_out, byte_count} !== {2'b11, 16'd2})
            $display("[TB] FAIL after_panel_reset: got valid=%b sleep=%b cnt=%0d want 1 1 2", tok_valid, sleep_out, byte_count);
        else passes++;
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({tok_valid, tok_data, tok_is_cmd, tok_param_idx, last_cmd, sleep_out, display_on,
             pixel_format, overflow, byte_count} !== 55'd0)
            $display("[TB] FAIL async_reset: got valid=%b last=%h sleep=%b ovf=%b cnt=%0d want all zero",
                     tok_valid, last_cmd, sleep_out, overflow, byte_count);
        else passes++;
        #5 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_decode();
        test_latency();
        test_overflow_drain();
        test_chip_select();
        test_param_idx();
        test_panel_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
